// File: rtl/iram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : iram_arbiter_if
// Description : Bundles the fetch port, loader port and RAM-wrapper signals
//               around the instruction-RAM arbiter. The slave modport is the
//               arbiter's view; the master modport is the surrounding
//               environment (requesters plus RAM wrapper).
// Revision    : 1.0 - initial release
// ============================================================================
interface iram_arbiter_if;

    // Fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    // Loader / debug port
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_hold;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        ld_err;

    // RAM wrapper side
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_hold,
        output ld_gnt, ld_rvalid, ld_rdata, ld_err,
        output mem_wr, mem_rd, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_hold,
        input  ld_gnt, ld_rvalid, ld_rdata, ld_err,
        input  mem_wr, mem_rd, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/iram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iram_arbiter
// Description : Shares the single-port instruction RAM between the core fetch
//               port and the loader/debug port. Loader has priority, but the
//               fetch port is forced through after STARVE_MAX consecutive
//               loader wins unless the loader holds the core. Read data comes
//               back one cycle after the grant, steered to the owning port.
// Revision    : 1.0 - initial release
// ============================================================================
module iram_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned IRAM_BYTES = 32768
) (
    input  wire logic     sclk,
    input  wire logic     rstn,
    iram_arbiter_if.slave bus
);

    localparam logic [3:0]  c_STARVE_MAX = 4'(STARVE_MAX);
    localparam logic [32:0] c_IRAM_LIMIT = 33'(IRAM_BYTES);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

    owner_e      owner_q,      owner_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        rsp_err_q,    rsp_err_d;
    logic        rsp_wr_q,     rsp_wr_d;

    logic        w_if_elig;
    logic        w_force_if;
    logic        w_ld_gnt;
    logic        w_if_gnt;
    logic        w_ld_wr;
    logic [31:0] w_addr;
    logic        w_oor;
    logic [31:0] w_rsp_data;

    // Grants are suppressed while rstn is low so no access is issued that the
    // cleared response tracker would then lose.
    assign w_if_elig  = rstn & bus.if_req & ~bus.ld_hold;
    assign w_force_if = w_if_elig & (starve_cnt_q == c_STARVE_MAX);
    assign w_ld_gnt   = rstn & bus.ld_req & ~w_force_if;
    assign w_if_gnt   = w_if_elig & ~w_ld_gnt;
    assign w_ld_wr    = w_ld_gnt & bus.ld_we;

    assign w_addr = w_ld_gnt ? bus.ld_addr :
                    w_if_gnt ? bus.if_addr : 32'd0;

    // Out-of-range accesses are still granted but never reach the RAM.
    assign w_oor = (w_ld_gnt | w_if_gnt) & ({1'b0, w_addr} >= c_IRAM_LIMIT);

    // RAM wrapper drive for the granted port
    assign bus.if_gnt    = w_if_gnt;
    assign bus.ld_gnt    = w_ld_gnt;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_rd    = (w_if_gnt | (w_ld_gnt & ~bus.ld_we)) & ~w_oor;
    assign bus.mem_wr    = w_ld_wr & ~w_oor;
    assign bus.mem_wdata = w_ld_wr ? bus.ld_wdata : 32'd0;

    // Next-state: starvation counter and capture of the granted access
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!w_if_elig || w_if_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (w_ld_gnt && (starve_cnt_q < c_STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        owner_d = OWN_NONE;
        if (w_ld_gnt) begin
            owner_d = OWN_LD;
        end else if (w_if_gnt) begin
            owner_d = OWN_IF;
        end

        rsp_err_d = w_oor;
        rsp_wr_d  = w_ld_wr;
    end

    // State registers; an asynchronous reset drops any outstanding response
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= 4'd0;
            rsp_err_q    <= 1'b0;
            rsp_wr_q     <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            rsp_err_q    <= rsp_err_d;
            rsp_wr_q     <= rsp_wr_d;
        end
    end

    // Response steering: only the owner sees data, and only for clean reads
    assign w_rsp_data    = (rsp_err_q | rsp_wr_q) ? 32'd0 : bus.mem_rdata;

    assign bus.if_rvalid = (owner_q == OWN_IF);
    assign bus.if_err    = (owner_q == OWN_IF) & rsp_err_q;
    assign bus.if_rdata  = (owner_q == OWN_IF) ? w_rsp_data : 32'd0;

    assign bus.ld_rvalid = (owner_q == OWN_LD);
    assign bus.ld_err    = (owner_q == OWN_LD) & rsp_err_q;
    assign bus.ld_rdata  = (owner_q == OWN_LD) ? w_rsp_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_iram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iram_arbiter
// Description : Directed bench for iram_arbiter. A driver applies one vector
//               per cycle, checks the combinational grant/memory drive and
//               queues the expected response; a monitor pops and compares
//               whenever a response appears. A small RAM model stands in for
//               the wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iram_arbiter;

    typedef struct {
        int          due;
        logic        ifv;
        logic        ldv;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic sclk = 1'b0;
    logic rstn;
    logic preload;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    rsp_t exp_q[$];

    logic [31:0] ram [0:63];

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    iram_arbiter_if bus ();

    iram_arbiter #(
        .STARVE_MAX (4),
        .IRAM_BYTES (32768)
    ) dut (
        .sclk (sclk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    // RAM wrapper model: one-cycle read latency, writes on the edge
    always @(posedge sclk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'd0;
            ram[4]        <= 32'h00A0_0093;
            bus.mem_rdata <= 32'd0;
        end else begin
            if (bus.mem_wr) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
            if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr[7:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; expected values are passed in by the caller
    task automatic step(input logic ifr, input logic [31:0] ifa,
                        input logic ldr, input logic ldwe,
                        input logic [31:0] lda, input logic [31:0] ldwd,
                        input logic hold,
                        input logic eg_if, input logic eg_ld,
                        input logic e_rd, input logic e_wr,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata,
                        input logic [31:0] e_rdata, input logic e_err);
        @(negedge sclk);
        bus.if_req   = ifr;
        bus.if_addr  = ifa;
        bus.ld_req   = ldr;
        bus.ld_we    = ldwe;
        bus.ld_addr  = lda;
        bus.ld_wdata = ldwd;
        bus.ld_hold  = hold;
        #1;
        chk("if_gnt",    32'(bus.if_gnt), 32'(eg_if));
        chk("ld_gnt",    32'(bus.ld_gnt), 32'(eg_ld));
        chk("mem_rd",    32'(bus.mem_rd), 32'(e_rd));
        chk("mem_wr",    32'(bus.mem_wr), 32'(e_wr));
        chk("mem_addr",  bus.mem_addr,    e_addr);
        chk("mem_wdata", bus.mem_wdata,   e_wdata);
        if (eg_if || eg_ld) exp_q.push_back('{cyc + 1, eg_if, eg_ld, e_rdata, e_err});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every response against the head of the queue
    initial begin
        rsp_t e;
        forever begin
            @(posedge sclk);
            #2;
            if (bus.if_rvalid || bus.ld_rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: if_rvalid=%0b ld_rvalid=%0b expected none (cycle %0d)",
                             bus.if_rvalid, bus.ld_rvalid, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(e.due));
                    chk("rvalid", {30'd0, bus.if_rvalid, bus.ld_rvalid}, {30'd0, e.ifv, e.ldv});
                    chk("if_rdata", bus.if_rdata, e.ifv ? e.rdata : 32'd0);
                    chk("ld_rdata", bus.ld_rdata, e.ldv ? e.rdata : 32'd0);
                    chk("if_err", 32'(bus.if_err), 32'(e.ifv & e.err));
                    chk("ld_err", 32'(bus.ld_err), 32'(e.ldv & e.err));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_rsp: no rvalid, expected ifv=%0b ldv=%0b due cycle %0d (cycle %0d)",
                         e.ifv, e.ldv, e.due, cyc);
            end
        end
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        rstn         = 1'b0;
        preload      = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_addr  = 32'd0;
        bus.ld_req   = 1'b0;
        bus.ld_we    = 1'b0;
        bus.ld_addr  = 32'd0;
        bus.ld_wdata = 32'd0;
        bus.ld_hold  = 1'b0;

        // Reset state
        repeat (3) @(negedge sclk);
        chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("rst_ld_rvalid", 32'(bus.ld_rvalid), 32'd0);
        chk("rst_if_rdata",  bus.if_rdata,       32'd0);
        chk("rst_ld_rdata",  bus.ld_rdata,       32'd0);
        chk("rst_errs",      {30'd0, bus.if_err, bus.ld_err}, 32'd0);
        chk("rst_mem_rdwr",  {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
        rstn    = 1'b1;
        preload = 1'b0;

        // Single fetch of word 4
        step(1, 32'h10, 0, 0, 0, 0, 0,  1, 0, 1, 0, 32'h10, 0, 32'h00A0_0093, 0);
        // Loader write, then fetch reads it back, then loader reads word 4
        step(0, 0, 1, 1, 32'h20, 32'hDEAD_BEEF, 0,  0, 1, 0, 1, 32'h20, 32'hDEAD_BEEF, 0, 0);
        step(1, 32'h20, 0, 0, 0, 0, 0,  1, 0, 1, 0, 32'h20, 0, 32'hDEAD_BEEF, 0);
        step(0, 0, 1, 0, 32'h10, 0, 0,  0, 1, 1, 0, 32'h10, 0, 32'h00A0_0093, 0);
        idle();

        // Starvation guard: L,L,L,L,F,L,L,L,L,F,L,L
        for (int i = 0; i < 12; i++) begin
            if (i == 4 || i == 9)
                step(1, 32'h10, 1, 0, 32'h20, 0, 0,  1, 0, 1, 0, 32'h10, 0, 32'h00A0_0093, 0);
            else
                step(1, 32'h10, 1, 0, 32'h20, 0, 0,  0, 1, 1, 0, 32'h20, 0, 32'hDEAD_BEEF, 0);
        end

        // ld_hold: loader wins every cycle, fetch never granted
        for (int i = 0; i < 12; i++)
            step(1, 32'h10, 1, 0, 32'h20, 0, 1,  0, 1, 1, 0, 32'h20, 0, 32'hDEAD_BEEF, 0);
        // Hold released: counter restarts from 0, so four loader wins then fetch
        for (int i = 0; i < 5; i++) begin
            if (i == 4)
                step(1, 32'h10, 1, 0, 32'h20, 0, 0,  1, 0, 1, 0, 32'h10, 0, 32'h00A0_0093, 0);
            else
                step(1, 32'h10, 1, 0, 32'h20, 0, 0,  0, 1, 1, 0, 32'h20, 0, 32'hDEAD_BEEF, 0);
        end
        idle();

        // Range boundaries
        step(1, 32'h7FFC, 0, 0, 0, 0, 0,  1, 0, 1, 0, 32'h7FFC, 0, 32'd0, 0);
        step(1, 32'h8000, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h8000, 0, 32'd0, 1);
        step(0, 0, 1, 1, 32'h8000, 32'h1234_5678, 0,  0, 1, 0, 0, 32'h8000, 32'h1234_5678, 32'd0, 1);
        step(0, 0, 1, 0, 32'h20, 0, 0,  0, 1, 1, 0, 32'h20, 0, 32'hDEAD_BEEF, 0);
        idle();
        idle();

        // Asynchronous reset while a fetch read is outstanding
        @(negedge sclk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        #1;
        chk("mid_rst_if_gnt", 32'(bus.if_gnt), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("mid_rst_if_gnt_low", 32'(bus.if_gnt), 32'd0);
        @(posedge sclk);
        #2;
        chk("in_rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        @(negedge sclk);
        bus.if_req = 1'b0;
        rstn       = 1'b1;
        @(posedge sclk);
        #2;
        chk("post_rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        idle();
        idle();

        // Fetch still works after the reset
        step(1, 32'h10, 0, 0, 0, 0, 0,  1, 0, 1, 0, 32'h10, 0, 32'h00A0_0093, 0);
        idle();
        idle();

        chk("rsp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
